// File: rtl/pio_loader.sv
// rtl/pio_loader.sv - replays a stored program and bring-up words onto the pio config port
module pio_loader #(
    parameter int ADDR_W = 5,
    parameter int DIN_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        plen,
    input  logic [1:0]        sm,
    input  logic [4:0]        wrap_end,
    input  logic [23:0]       div,
    input  logic [31:0]       pin_grps,
    input  logic [3:0]        en_mask,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    output logic [3:0]        action,
    output logic [4:0]        index,
    output logic [1:0]        mindex,
    output logic [DIN_W-1:0]  din,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] A_NONE  = 4'd0;
    localparam logic [3:0] A_INSTR = 4'd1;
    localparam logic [3:0] A_PEND  = 4'd2;
    localparam logic [3:0] A_GRPS  = 4'd5;
    localparam logic [3:0] A_EN    = 4'd6;
    localparam logic [3:0] A_DIV   = 4'd7;

    // Largest program that fits the pio instruction memory.
    localparam logic [6:0] MAX_LEN = 7'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_INSTR,
        S_PEND,
        S_DIV,
        S_GRPS,
        S_EN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         plen_q, plen_d;
    logic [4:0]         wrap_q, wrap_d;
    logic [23:0]        div_q, div_d;
    logic [31:0]        grps_q, grps_d;
    logic [3:0]         en_q, en_d;
    logic [1:0]         mindex_q, mindex_d;
    logic [4:0]         index_q, index_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [5:0]         addr_ahead;

    // State and latched-parameter registers; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            plen_q     <= '0;
            wrap_q     <= '0;
            div_q      <= '0;
            grps_q     <= '0;
            en_q       <= '0;
            mindex_q   <= '0;
            index_q    <= '0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            plen_q     <= plen_d;
            wrap_q     <= wrap_d;
            div_q      <= div_d;
            grps_q     <= grps_d;
            en_q       <= en_d;
            mindex_q   <= mindex_d;
            index_q    <= index_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state and port drive. The memory read runs one word ahead of the
    // INSTR being issued, so addr_ahead is the word needed two cycles out.
    always_comb begin
        state_d    = state_q;
        plen_d     = plen_q;
        wrap_d     = wrap_q;
        div_d      = div_q;
        grps_d     = grps_q;
        en_d       = en_q;
        mindex_d   = mindex_q;
        index_d    = index_q;
        mem_addr_d = mem_addr_q;
        done_d     = done_q;
        err_d      = 1'b0;
        action     = A_NONE;
        din        = '0;
        busy       = 1'b0;
        addr_ahead = {1'b0, index_q} + 6'd2;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d = 1'b0;
                    if ({1'b0, plen} > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        plen_d     = plen;
                        wrap_d     = wrap_end;
                        div_d      = div;
                        grps_d     = pin_grps;
                        en_d       = en_mask;
                        mindex_d   = sm;
                        mem_addr_d = '0;
                        state_d    = (plen == 6'd0) ? S_PEND : S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                busy       = 1'b1;
                index_d    = '0;
                mem_addr_d = (plen_q > 6'd1) ? ADDR_W'(1) : '0;
                state_d    = S_INSTR;
            end
            S_INSTR: begin
                busy   = 1'b1;
                action = A_INSTR;
                din    = DIN_W'({16'h0, mem_data});
                if ({1'b0, index_q} == plen_q - 6'd1) begin
                    state_d = S_PEND;
                end else begin
                    index_d = index_q + 5'd1;
                    if (addr_ahead < plen_q) begin
                        mem_addr_d = ADDR_W'(addr_ahead);
                    end
                end
            end
            S_PEND: begin
                busy    = 1'b1;
                action  = A_PEND;
                din     = DIN_W'({27'h0, wrap_q});
                state_d = S_DIV;
            end
            S_DIV: begin
                busy    = 1'b1;
                action  = A_DIV;
                din     = DIN_W'({8'h0, div_q});
                state_d = S_GRPS;
            end
            S_GRPS: begin
                busy    = 1'b1;
                action  = A_GRPS;
                din     = DIN_W'(grps_q);
                state_d = S_EN;
            end
            S_EN: begin
                busy    = 1'b1;
                action  = A_EN;
                din     = DIN_W'({28'h0, en_q});
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr = mem_addr_q;
    assign index    = index_q;
    assign mindex   = mindex_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pio_loader.sv
// tb/tb_pio_loader.sv - scoreboard bench for pio_loader
module tb_pio_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  plen;
    logic [1:0]  sm;
    logic [4:0]  wrap_end;
    logic [23:0] div;
    logic [31:0] pin_grps;
    logic [3:0]  en_mask;
    logic [4:0]  mem_addr;
    logic [15:0] mem_data;
    logic [3:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] mem [32];
    int          cyc = 0;
    int          tests_run = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        int         c;
        logic [3:0] a;
        logic [4:0] i;
        bit         chk_i;
        logic [1:0] m;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    pio_loader #(.ADDR_W(5), .DIN_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .plen(plen), .sm(sm),
        .wrap_end(wrap_end), .div(div), .pin_grps(pin_grps), .en_mask(en_mask),
        .mem_addr(mem_addr), .mem_data(mem_data), .action(action), .index(index),
        .mindex(mindex), .din(din), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mem_data <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mon_en && action !== 4'd0) begin
            tests_run++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_action cyc=%0d action=%0d index=%0d din=%h", cyc, action, index, din);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.c || action !== e.a || (e.chk_i && index !== e.i) || mindex !== e.m || din !== e.d) begin
                    fails++;
                    $display("FAIL action_stream got cyc=%0d act=%0d idx=%0d mi=%0d din=%h want cyc=%0d act=%0d idx=%0d mi=%0d din=%h",
                             cyc, action, index, mindex, din, e.c, e.a, e.i, e.m, e.d);
                end
            end
        end
    end

    task automatic push(input int c, input logic [3:0] a, input logic [4:0] i, input bit ci,
                        input logic [1:0] m, input logic [31:0] d);
        exp_t x;
        x.c = c; x.a = a; x.i = i; x.chk_i = ci; x.m = m; x.d = d;
        sb.push_back(x);
    endtask

    task automatic go(input logic [5:0] pl, input logic [1:0] s, input logic [4:0] we,
                      input logic [23:0] dv, input logic [31:0] pg, input logic [3:0] em,
                      input bit expect_run, output int t);
        int base;
        plen = pl; sm = s; wrap_end = we; div = dv; pin_grps = pg; en_mask = em;
        start = 1'b1;
        t = cyc;
        if (expect_run) begin
            for (int k = 0; k < int'(pl); k++)
                push(t + 2 + k, 4'd1, 5'(k), 1'b1, s, {16'h0, mem[k]});
            base = (pl == 6'd0) ? t + 1 : t + int'(pl) + 2;
            push(base,     4'd2, 5'd0, 1'b0, s, {27'h0, we});
            push(base + 1, 4'd7, 5'd0, 1'b0, s, {8'h0, dv});
            push(base + 2, 4'd5, 5'd0, 1'b0, s, pg);
            push(base + 3, 4'd6, 5'd0, 1'b0, s, {28'h0, em});
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        plen = '0; sm = '0; wrap_end = '0; div = '0; pin_grps = '0; en_mask = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({action, index, mindex, din, mem_addr, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs act=%0d idx=%0d mi=%0d din=%h addr=%0d busy=%b done=%b err=%b required all 0",
                     action, index, mindex, din, mem_addr, busy, done, err);
        end
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_square();
        int t;
        mem[0] = 16'hE081; mem[1] = 16'hE001;
        go(6'd2, 2'd0, 5'd1, 24'h000280, 32'h1, 4'd1, 1'b1, t);
        for (int c = 1; c <= 8; c++) begin
            tests_run++;
            if (busy !== (c <= 7) || done !== (c == 8)) begin
                fails++;
                $display("FAIL square_busy_done cycle=T+%0d busy=%b done=%b required busy=%b done=%b",
                         c, busy, done, (c <= 7), (c == 8));
            end
            if (c == 1) begin
                tests_run++;
                if (mem_addr !== 5'd0) begin
                    fails++;
                    $display("FAIL square_fetch_addr got=%0d required=0", mem_addr);
                end
            end
            @(negedge clk);
        end
        drain(20);
    endtask

    task automatic test_full();
        int t;
        for (int k = 0; k < 32; k++) mem[k] = 16'(k * 3);
        go(6'd32, 2'd1, 5'd31, 24'h123456, 32'hDEADBEEF, 4'hF, 1'b1, t);
        for (int c = 1; c <= 37; c++) begin
            tests_run++;
            if (mem_addr !== ((c <= 32) ? 5'(c - 1) : 5'd31)) begin
                fails++;
                $display("FAIL full_mem_addr cycle=T+%0d got=%0d required=%0d",
                         c, mem_addr, (c <= 32) ? c - 1 : 31);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL full_done got=%b required=1", done);
        end
        drain(10);
    endtask

    task automatic test_plen0();
        int t;
        go(6'd0, 2'd2, 5'd7, 24'h00ABCD, 32'h0F0F0F0F, 4'd4, 1'b1, t);
        for (int c = 1; c <= 5; c++) begin
            tests_run++;
            if (mem_addr !== 5'd0 || busy !== (c <= 4) || done !== (c == 5)) begin
                fails++;
                $display("FAIL plen0_state cycle=T+%0d addr=%0d busy=%b done=%b required addr=0 busy=%b done=%b",
                         c, mem_addr, busy, done, (c <= 4), (c == 5));
            end
            @(negedge clk);
        end
        drain(10);
    endtask

    task automatic test_err();
        int t;
        go(6'd33, 2'd3, 5'd1, 24'h1, 32'h1, 4'd1, 1'b0, t);
        tests_run++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL err_pulse err=%b busy=%b done=%b required err=1 busy=0 done=0", err, busy, done);
        end
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            tests_run++;
            if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL err_after cycle=T+%0d err=%b busy=%b done=%b required 0 0 0", c, err, busy, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        go(6'd2, 2'd1, 5'd3, 24'h000AAA, 32'h5, 4'd2, 1'b1, t);
        @(negedge clk);
        plen = 6'd5; div = 24'h000BBB; wrap_end = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(20);
        tests_run++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done got=%b required=1", done);
        end
        go(6'd3, 2'd3, 5'd9, 24'h000BBB, 32'h77, 4'd8, 1'b1, t);
        drain(20);
        tests_run++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL rerun_done got=%b required=1", done);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        mem[0] = 16'hE081; mem[1] = 16'hE001;
        go(6'd2, 2'd2, 5'd1, 24'h000280, 32'h1, 4'd1, 1'b0, t);
        push(t + 2, 4'd1, 5'd0, 1'b1, 2'd2, 32'hE081);
        push(t + 3, 4'd1, 5'd1, 1'b1, 2'd2, 32'hE001);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({action, index, mindex, din, mem_addr, busy, done, err} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs act=%0d idx=%0d mi=%0d din=%h addr=%0d busy=%b done=%b err=%b required all 0",
                     action, index, mindex, din, mem_addr, busy, done, err);
        end
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL reset_mid_pending got=%0d required=0", sb.size());
            sb.delete();
        end
        reset = 1'b1;
        @(negedge clk);
        go(6'd2, 2'd0, 5'd1, 24'h000280, 32'h1, 4'd1, 1'b1, t);
        drain(20);
        tests_run++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_rerun_done got=%b required=1", done);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = '0;
        test_reset();
        test_square();
        test_full();
        test_plen0();
        test_err();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
